// File: rtl/shift_sub_divide.sv
// shift_sub_divide: 32/16 unsigned restoring divider, one quotient bit per clock with a start/ready handshake.
// Define SHIFT_SUB_DIV_ERR_EN to flag divide-by-zero/overflow and finish those operations after one cycle.
module shift_sub_divide (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  input  logic        start,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ready,
  output logic        error
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [16:0] r_q, r_d, t, r_step;
  logic [15:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d, q_step;
  logic [3:0] cnt_q, cnt_d;
  logic err_q, err_d, accept, last, ge, ovf, run;
`ifdef SHIFT_SUB_DIV_ERR_EN
  assign ovf = (divisor == 16'd0) || (dividend[31:16] >= divisor);
`else
  assign ovf = 1'b0;
`endif
  assign run    = (state_q == RUN);
  assign accept = ready && start;
  // An error-flagged operation leaves RUN after a single cycle instead of 16 steps
  assign last   = run && ((cnt_q == 4'd15) || err_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (accept)    state_d = RUN;
    else if (last) state_d = DONE;
  end
  always_comb begin
    ready     = (state_q != RUN);
    quotient  = quo_q;
    remainder = rem_q;
    error     = err_q;
  end
  always_comb begin
    t      = {r_q[15:0], q_q[15]};
    ge     = (t >= {1'b0, d_q});
    r_step = ge ? t - {1'b0, d_q} : t;
    q_step = {q_q[14:0], ge};
    r_d    = accept ? {1'b0, dividend[31:16]} : run ? r_step : r_q;
    q_d    = accept ? dividend[15:0] : run ? q_step : q_q;
    d_d    = accept ? divisor : d_q;
    cnt_d  = accept ? 4'd0 : run ? cnt_q + 4'd1 : cnt_q;
    err_d  = accept ? ovf : err_q;
    quo_d  = !last ? quo_q : err_q ? 16'hFFFF : q_step;
    rem_d  = !last ? rem_q : err_q ? q_q : r_step[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_shift_sub_divide.sv
// tb_shift_sub_divide: directed and randomized checks of shift_sub_divide against an arithmetic reference model.
module tb_shift_sub_divide;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        ready, error;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] prev_q = '0;
  logic [15:0] prev_r = '0;
  bit          prev_known = 1'b1;
`ifdef SHIFT_SUB_DIV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  shift_sub_divide dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor), .start(start),
    .quotient(quotient), .remainder(remainder), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_ready(input int pre, output int lat);
    lat = pre;
    while (!ready && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones quotient and the low dividend half
  task automatic ref_div(input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic e, output int lat);
    if (b == 16'd0) begin
      q   = 16'hFFFF;
      r   = a[15:0];
      e   = ERR_EN;
      lat = ERR_EN ? 1 : 16;
    end else begin
      q   = 16'(a / {16'd0, b});
      r   = 16'(a % {16'd0, b});
      e   = 1'b0;
      lat = 16;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [15:0] b);
    logic [15:0] eq, er;
    logic        ee;
    int          el, lat;
    ref_div(a, b, eq, er, ee, el);
    start_op(a, b);
    if (prev_known) chk({tag, "_hold"}, {16'd0, quotient}, {16'd0, prev_q});
    wait_ready(0, lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
    chk({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
    chk({tag, "_err"}, {31'd0, error}, {31'd0, ee});
    prev_q = eq;
    prev_r = er;
    prev_known = 1'b1;
  endtask

  initial begin
    int          lat;
    logic [31:0] a;
    logic [15:0] b;
    dividend = 32'h1234_5678;
    divisor  = 16'h0042;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_q", {16'd0, quotient}, 32'd0);
    chk("rst_r", {16'd0, remainder}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    rst_n = 1'b1;

    run_check("d48_4", 32'd48, 16'd4);
    run_check("d100000_7", 32'd100000, 16'd7);
    run_check("dmax", 32'hFFFE_0001, 16'hFFFF);

    // start pulsed mid-run with other operands must be ignored
    start_op(32'd48, 16'd4);
    repeat (3) @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_ready(4, lat);
    chk("ign_lat", lat, 16);
    chk("ign_q", {16'd0, quotient}, 32'd12);
    chk("ign_r", {16'd0, remainder}, 32'd0);
    prev_q = 16'd12;
    prev_r = 16'd0;
    run_check("d1000_3", 32'd1000, 16'd3);

    // start held high across two operations
    @(negedge clk);
    dividend = 32'd48;
    divisor  = 16'd4;
    start    = 1'b1;
    @(negedge clk);
    wait_ready(0, lat);
    chk("b2b1_lat", lat, 16);
    chk("b2b1_q", {16'd0, quotient}, 32'd12);
    chk("b2b1_r", {16'd0, remainder}, 32'd0);
    dividend = 32'd49;
    @(negedge clk);
    chk("b2b_ready_low", {31'd0, ready}, 32'd0);
    wait_ready(0, lat);
    start = 1'b0;
    chk("b2b2_lat", lat, 16);
    chk("b2b2_q", {16'd0, quotient}, 32'd12);
    chk("b2b2_r", {16'd0, remainder}, 32'd1);
    prev_q = 16'd12;
    prev_r = 16'd1;

    run_check("dzero", 32'h0005_1234, 16'd0);

    // overflow with nonzero divisor: values defined only when the error path is built in
    start_op(32'h0005_0000, 16'd5);
    wait_ready(0, lat);
    chk("ovf_lat", lat, ERR_EN ? 1 : 16);
    chk("ovf_err", {31'd0, error}, {31'd0, ERR_EN});
`ifdef SHIFT_SUB_DIV_ERR_EN
    chk("ovf_q", {16'd0, quotient}, 32'h0000_FFFF);
    chk("ovf_r", {16'd0, remainder}, 32'd0);
`endif
    prev_known = 1'b0;

    // asynchronous reset mid-run
    start_op(32'd48, 16'd4);
    repeat (7) @(negedge clk);
    chk("abort_busy", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_q", {16'd0, quotient}, 32'd0);
    chk("abort_r", {16'd0, remainder}, 32'd0);
    chk("abort_err", {31'd0, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = '0;
    prev_r = '0;
    prev_known = 1'b1;
    run_check("after_abort", 32'd48, 16'd4);

    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3) begin
        b = 16'd0;
        a = $urandom;
      end else begin
        b = 16'($urandom_range(1, 65535));
        a = {16'($urandom % b), 16'($urandom)};
      end
      run_check($sformatf("rnd%0d", i), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
